// File: rtl/dist_sensor_pkg.sv
// Shared types and default timing constants for the ultrasonic distance sensor.
package dist_sensor_pkg;

  localparam int unsigned TRIG_CYC_DEF    = 1000;
  localparam int unsigned CYC_PER_CM_DEF  = 5800;
  localparam int unsigned TIMEOUT_CYC_DEF = 2500000;
  localparam int unsigned PERIOD_CYC_DEF  = 6000000;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DIST_W = 16;

  localparam logic [DIST_W-1:0] DIST_NONE = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG    = 3'd1,
    WAIT_HI = 3'd2,
    MEAS    = 3'd3,
    GAP     = 3'd4
  } state_t;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for the raw echo input plus rise/fall pulses of the synchronized level.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_echo,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_s1;
  logic r_s2;
  logic r_s2_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s2_d <= 1'b0;
    end else begin
      r_s1   <= i_echo;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  assign o_rise_c = r_s2 & ~r_s2_d;
  assign o_fall_c = ~r_s2 & r_s2_d;

endmodule

// File: rtl/dist_sensor.sv
// Periodic ultrasonic ranging: trigger pulse, echo-width measurement in cm, no-echo timeout.
module dist_sensor
  import dist_sensor_pkg::*;
#(
  parameter int unsigned TRIG_CYC    = TRIG_CYC_DEF,
  parameter int unsigned CYC_PER_CM  = CYC_PER_CM_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned PERIOD_CYC  = PERIOD_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] dist_v,
  output logic              dist_valid,
  output logic              timeout,
  output logic              busy
);

  state_t            r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic [CNT_W-1:0]  r_period, w_period_nx;
  logic [CNT_W-1:0]  r_sub, w_sub_nx;
  logic [DIST_W-1:0] r_cm, w_cm_nx;
  logic [DIST_W-1:0] r_dist, w_dist_nx;
  logic              r_trig, r_valid, r_timeout, r_busy;
  logic              w_valid_nx, w_timeout_nx;
  logic              w_rise, w_fall;

  echo_sync u_echo_sync (
    .clk      (clk),
    .rst      (rst),
    .i_echo   (echo),
    .o_rise_c (w_rise),
    .o_fall_c (w_fall)
  );

  // Next-state and datapath updates
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt + 1'b1;
    w_period_nx  = r_period + 1'b1;
    w_sub_nx     = r_sub;
    w_cm_nx      = r_cm;
    w_dist_nx    = r_dist;
    w_valid_nx   = 1'b0;
    w_timeout_nx = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nx    = '0;
        w_period_nx = '0;
        if (en) w_state_nx = TRIG;
      end
      TRIG: begin
        if (r_cnt == CNT_W'(TRIG_CYC - 1)) begin
          w_state_nx = WAIT_HI;
          w_cnt_nx   = '0;
        end
      end
      WAIT_HI: begin
        // The cycle that shows the rising edge is the first high cycle, so it is counted
        if (w_rise) begin
          w_state_nx = MEAS;
          w_cnt_nx   = '0;
          if (CYC_PER_CM == 1) begin
            w_sub_nx = '0;
            w_cm_nx  = DIST_W'(1);
          end else begin
            w_sub_nx = CNT_W'(1);
            w_cm_nx  = '0;
          end
        end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_state_nx   = GAP;
          w_dist_nx    = DIST_NONE;
          w_timeout_nx = 1'b1;
        end
      end
      MEAS: begin
        if (w_fall) begin
          w_state_nx = GAP;
          w_dist_nx  = r_cm;
          w_valid_nx = 1'b1;
        end else if (r_sub == CNT_W'(CYC_PER_CM - 1)) begin
          w_sub_nx = '0;
          if (r_cm != DIST_NONE) w_cm_nx = r_cm + 1'b1;
        end else begin
          w_sub_nx = r_sub + 1'b1;
        end
      end
      GAP: begin
        if (r_period >= CNT_W'(PERIOD_CYC - 1)) begin
          if (en) begin
            w_state_nx  = TRIG;
            w_cnt_nx    = '0;
            w_period_nx = '0;
          end else begin
            w_state_nx = IDLE;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State, counters and registered outputs; trig follows the TRIG state one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_sub     <= '0;
      r_cm      <= '0;
      r_dist    <= '0;
      r_trig    <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_period  <= w_period_nx;
      r_sub     <= w_sub_nx;
      r_cm      <= w_cm_nx;
      r_dist    <= w_dist_nx;
      r_trig    <= (r_state == TRIG);
      r_valid   <= w_valid_nx;
      r_timeout <= w_timeout_nx;
      r_busy    <= (w_state_nx != IDLE);
    end
  end

  assign trig       = r_trig;
  assign dist_v     = r_dist;
  assign dist_valid = r_valid;
  assign timeout    = r_timeout;
  assign busy       = r_busy;

endmodule

// File: tb/tb_dist_sensor.sv
// Directed bench for dist_sensor with short timing parameters and hand-computed expectations.
module tb_dist_sensor;

  logic        clk;
  logic        rst;
  logic        en;
  logic        echo;
  logic        trig;
  logic [15:0] dist_v;
  logic        dist_valid;
  logic        timeout;
  logic        busy;

  int n_vec;
  int n_err;
  int cyc;
  int both_hi;
  int rise_cyc[5];

  dist_sensor #(
    .TRIG_CYC    (4),
    .CYC_PER_CM  (10),
    .TIMEOUT_CYC (50),
    .PERIOD_CYC  (200)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .echo       (echo),
    .trig       (trig),
    .dist_v     (dist_v),
    .dist_valid (dist_valid),
    .timeout    (timeout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (dist_valid && timeout) both_hi++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Wait for trig to go high, then measure its width; leaves us on the first trig-low sample
  task automatic trig_pulse(input string tag);
    int n;
    n = 0;
    while (!trig && n < 400) begin tick(); n++; end
    chk({tag, "_trig_seen"}, 32'(trig), 1);
    n = 0;
    while (trig && n < 20) begin n++; tick(); end
    chk({tag, "_trig_width"}, 32'(n), 4);
  endtask

  task automatic echo_meas(input string tag, input int hi, input logic [15:0] exp_d);
    int n;
    echo = 1'b1;
    repeat (hi) tick();
    echo = 1'b0;
    n = 0;
    while (!dist_valid && n < 400) begin tick(); n++; end
    chk({tag, "_valid_lat"}, 32'(n), 3);
    chk({tag, "_dist"}, 32'(dist_v), 32'(exp_d));
    chk({tag, "_no_to"}, 32'(timeout), 0);
    tick();
    chk({tag, "_valid_1cyc"}, 32'(dist_valid), 0);
    chk({tag, "_dist_hold"}, 32'(dist_v), 32'(exp_d));
  endtask

  task automatic wait_timeout(input string tag);
    int n;
    int nv;
    n  = 0;
    nv = 0;
    while (!timeout && n < 400) begin tick(); n++; if (dist_valid) nv++; end
    // WAIT_HI is entered one cycle before trig is seen low
    chk({tag, "_to_lat"}, 32'(n), 49);
    chk({tag, "_dist_none"}, 32'(dist_v), 32'hFFFF);
    chk({tag, "_no_valid"}, 32'(nv), 0);
    tick();
    chk({tag, "_to_1cyc"}, 32'(timeout), 0);
  endtask

  initial begin
    int n;
    int hi_tab[5];
    logic [15:0] d_tab[5];
    hi_tab = '{123, 9, 10, 59, 0};
    d_tab  = '{16'd12, 16'd0, 16'd1, 16'd5, 16'hFFFF};
    n_vec = 0; n_err = 0; cyc = 0; both_hi = 0;
    rst = 1'b1; en = 1'b0; echo = 1'b0;
    repeat (3) tick();
    chk("rst_trig", 32'(trig), 0);
    chk("rst_dist", 32'(dist_v), 0);
    chk("rst_valid", 32'(dist_valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_busy", 32'(busy), 0);

    // Five periodic measurements with en held high
    rst = 1'b0; en = 1'b1;
    tick();
    chk("trig_lat1", 32'(trig), 0);
    chk("busy_trig", 32'(busy), 1);
    tick();
    chk("trig_lat2", 32'(trig), 1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) chk("dist_hold_period", 32'(dist_v), 32'(d_tab[k-1]));
      n = 0;
      while (!trig && n < 400) begin tick(); n++; end
      rise_cyc[k] = cyc;
      if (k > 0) chk("trig_spacing", 32'(rise_cyc[k] - rise_cyc[k-1]), 200);
      trig_pulse("per");
      if (hi_tab[k] > 0) echo_meas("per", hi_tab[k], d_tab[k]);
      else wait_timeout("per");
    end

    // Reset in the middle of a measurement
    trig_pulse("rstm");
    echo = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    chk("rstm_trig", 32'(trig), 0);
    chk("rstm_dist", 32'(dist_v), 0);
    chk("rstm_busy", 32'(busy), 0);
    rst = 1'b0; en = 1'b0; echo = 1'b0;
    n = 0;
    repeat (40) begin tick(); if (dist_valid || timeout) n++; end
    chk("rstm_no_pulse", 32'(n), 0);

    // en dropped mid-measurement: result still delivered, then back to IDLE
    en = 1'b1;
    trig_pulse("endrop");
    echo = 1'b1;
    repeat (10) tick();
    en = 1'b0;
    repeat (49) tick();
    echo = 1'b0;
    n = 0;
    while (!dist_valid && n < 400) begin tick(); n++; end
    chk("endrop_valid_lat", 32'(n), 3);
    chk("endrop_dist", 32'(dist_v), 5);
    n = 0;
    while (busy && n < 300) begin tick(); n++; end
    chk("endrop_idle", 32'(busy), 0);
    n = 0;
    repeat (300) begin tick(); if (trig) n++; end
    chk("endrop_no_trig", 32'(n), 0);

    // Echo stuck high before the trigger must not start a measurement
    rst = 1'b1; echo = 1'b1;
    repeat (2) tick();
    rst = 1'b0; en = 1'b1;
    trig_pulse("stuck");
    wait_timeout("stuck");
    echo = 1'b0;

    chk("valid_and_timeout", 32'(both_hi), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dist_sensor.md
DIST_SENSOR -- requirements
Module: dist_sensor

Interface
REQ-001 Parameter TRIG_CYC, 1000, width of the trigger pulse in clk cycles.
REQ-002 Parameter CYC_PER_CM, 5800, echo-high clk cycles per 1 cm of distance.
REQ-003 Parameter TIMEOUT_CYC, 2500000, maximum wait, in clk cycles, for the echo rising edge.
REQ-004 Parameter PERIOD_CYC, 6000000, spacing in clk cycles between successive trigger rising edges.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 en  in  1  enables periodic measurements.
REQ-008 echo  in  1  asynchronous echo from the ultrasonic sensor.
REQ-009 trig  out  1  trigger pulse to the sensor, registered.
REQ-010 dist_v  out  16  latest distance in cm; 16'hFFFF means no echo.
REQ-011 dist_valid  out  1  single-cycle pulse when dist_v updates with a measurement.
REQ-012 timeout  out  1  single-cycle pulse when dist_v updates to 16'hFFFF because no echo arrived.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 echo SHALL pass through a 2-flop synchronizer; echo_s (the synchronized echo) and its edge detects SHALL drive all decisions.
REQ-015 The FSM SHALL have states IDLE, TRIG, WAIT_HI, MEAS and GAP.
REQ-016 IDLE: trig=0; when en=1, go to TRIG next cycle and clear the period counter.
REQ-017 TRIG: trig=1 for exactly TRIG_CYC cycles, then go to WAIT_HI.
REQ-018 WAIT_HI: the FSM SHALL leave only on a rising edge of echo_s, not on level-high, so a stuck-high echo is ignored.
REQ-019 WAIT_HI rising edge: clear the cycle and cm counters and go to MEAS.
REQ-020 WAIT_HI timeout: after TIMEOUT_CYC cycles in WAIT_HI, set dist_v=16'hFFFF, pulse timeout, and go to GAP.
REQ-021 MEAS counting: the sub-counter SHALL wrap at CYC_PER_CM-1 and increment the cm counter on each wrap.
REQ-022 MEAS saturation: the cm counter SHALL saturate at 16'hFFFF.
REQ-023 MEAS falling edge: on a falling edge of echo_s, dist_v SHALL load the cm count, giving floor(high_cycles/CYC_PER_CM).
REQ-024 On that same falling edge, dist_valid SHALL pulse in the first cycle the new dist_v is visible, and the FSM SHALL go to GAP.
REQ-025 GAP: when the period counter reaches PERIOD_CYC-1 (counted from TRIG entry), go to TRIG if en=1, else to IDLE.
REQ-026 Deasserting en mid-measurement SHALL NOT abort it; the result SHALL be delivered, then the FSM returns to IDLE from GAP.
REQ-027 dist_v SHALL hold its value between updates; dist_valid and timeout SHALL never be high in the same cycle.
REQ-028 Latency from the raw echo falling edge to dist_valid SHALL be 3 clk cycles (2 synchronizer + 1 register).

Reset
REQ-029 While rst=1, the FSM SHALL go to IDLE, all counters and synchronizer flops to 0, and trig, dist_v, dist_valid, timeout and busy to 0.
REQ-030 rst SHALL override any state, including mid-MEAS; no dist_valid or timeout pulse SHALL follow an aborted measurement.
REQ-031 After rst deasserts with en=1, trig SHALL rise 2 cycles later (IDLE -> TRIG).

Structure
REQ-032 Package dist_sensor_pkg SHALL hold the state enum, the default parameter constants and DIST_NONE=16'hFFFF.
REQ-033 A single sub-module, echo_sync, SHALL implement the 2-flop synchronizer plus rise/fall pulses; all else is in dist_sensor.

Verification (TRIG_CYC=4, CYC_PER_CM=10, TIMEOUT_CYC=50, PERIOD_CYC=200)
REQ-034 en=1, echo high 123 cycles after trig falls -> trig high exactly 4 cycles; dist_v=12; one dist_valid pulse 3 cycles after echo falls.
REQ-035 en=1, echo held 0 -> timeout pulse 50 cycles after WAIT_HI entry; dist_v=16'hFFFF; dist_valid stays 0.
REQ-036 echo high 9 cycles -> dist_v=0 with dist_valid; echo stuck high before trig -> no MEAS entry, timeout fires.
REQ-037 rst pulsed mid-MEAS -> next cycle trig=0, dist_v=0, busy=0; no valid or timeout pulse afterwards.
REQ-038 en dropped during MEAS -> result still delivered; FSM reaches IDLE; no further trig.
REQ-039 en held 1 over 5 measurements -> trig rising edges exactly 200 cycles apart.
